csa_accum_ctrl: RTL

Sequential multi-operand accumulator controller built around a 3:2 carry-save compression stage. It accepts a stream of unsigned operands over a valid/ready handshake and folds each one into a redundant (sum, carry) register pair, one compression per cycle. On the last operand it performs a single carry-propagate resolve and presents the result on an output handshake. It sits between operand producers (e.g. partial-product generators) and downstream consumers of reduced sums.

---
 rtl/csa_accum_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl
// ---------------------------------------------------------------------------
// Multi-operand accumulator controller. Operands arrive one at a time over a
// valid/ready handshake. Each accepted operand goes through a 3:2 carry-save
// compression into a redundant (sum, carry) register pair. When the last
// operand has been folded in, the pair is resolved once with a carry-propagate
// add. The result is then offered on an output handshake.
//
// Handshake rule, which applies to both sides: a transfer happens on a rising
// clk edge where valid and ready are both high. valid, once raised, is not
// lowered before the transfer. ready may depend on state but never on valid.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand valid
//   in_ready   operand can be accepted (IDLE / ACCUM)
//   in_data    unsigned operand, zero-extended to ACC_WIDTH
//   in_last    final operand of the accumulation
//   out_valid  result valid (DONE)
//   out_ready  consumer takes the result
//   out_sum    resolved sum modulo 2^ACC_WIDTH
//   out_count  number of operands folded in
//   out_trunc  accumulation was cut off at MAX_OPS
//   busy       high in every state except IDLE
//   dbg_state  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module csa_accum_ctrl #(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 24,
   parameter int MAX_OPS   = 256,
   localparam int CNT_W    = $clog2(MAX_OPS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0]     out_count,
   output logic                 out_trunc,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] s_q, s_d;
   logic [ACC_WIDTH-1:0] c_q, c_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 trunc_q, trunc_d;

   logic                 accept;
   logic [ACC_WIDTH-1:0] x;
   logic [ACC_WIDTH-1:0] s_base;
   logic [ACC_WIDTH-1:0] c_base;
   logic [CNT_W-1:0]     cnt_base;
   logic [CNT_W-1:0]     cnt_inc;

   assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign accept    = in_valid & in_ready;
   assign out_sum   = sum_q;
   assign out_count = count_q;
   assign out_trunc = trunc_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         count_q <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         trunc_q <= trunc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      count_d = count_q;
      trunc_d = trunc_q;

      // An accept in IDLE starts a fresh accumulation. Whatever is left in
      // the S/C/count registers from the previous run is ignored.
      x        = ACC_WIDTH'(in_data);
      s_base   = (state_q == IDLE) ? '0 : s_q;
      c_base   = (state_q == IDLE) ? '0 : c_q;
      cnt_base = (state_q == IDLE) ? '0 : cnt_q;
      cnt_inc  = cnt_base + CNT_W'(1);

      case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               // 3:2 compression. The carry word is shifted left one bit,
               // and its top bit falls off, which gives modulo 2^ACC_WIDTH.
               s_d   = s_base ^ c_base ^ x;
               c_d   = ((s_base & c_base) | (s_base & x) | (c_base & x)) << 1;
               cnt_d = cnt_inc;
               if (in_last) begin
                  state_d = RESOLVE;
               end else if (cnt_inc == MAX_CNT) begin
                  state_d = RESOLVE;
                  trunc_d = 1'b1;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         RESOLVE: begin
            sum_d   = s_q + c_q;
            count_d = cnt_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
               trunc_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
